rx_data_buffer: RTL

RX_DATA_BUFFER -- requirements
Module: rx_data_buffer

---
 rtl/rx_data_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rx_data_buffer.sv
// ----------------------------------------------------------------------------
// rx_data_buffer
//   Byte FIFO between the USB receive path (writer) and an AHB-side consumer
//   (reader). The head byte is shown ahead on rx_data without a read strobe.
//   Occupancy/empty/full come straight from registered state, so the strobes
//   have no combinational path to them.
//
// Optional feature:
//   RX_BUFFER_OVERFLOW_FLAG_EN defined   -> overflow_err is a sticky flag that
//                                           is set when a write is dropped
//                                           because the buffer is full. It is
//                                           cleared by flush or reset.
//   RX_BUFFER_OVERFLOW_FLAG_EN undefined -> overflow_err is tied to 0.
//
// Parameters:
//   DEPTH                : entries, power of two, 4..64
//
// Ports:
//   clk                  : system clock, rising edge
//   n_rst                : asynchronous active-low reset (also clears array)
//   store_rx_packet_data : write strobe, one byte per asserted cycle
//   rx_packet_data[7:0]  : write data
//   get_rx_data          : read strobe, one byte per asserted cycle
//   flush                : synchronous clear, overrides same-cycle store/get
//   rx_data[7:0]         : head byte, valid while buffer_empty = 0
//   buffer_occupancy[6:0]: entry count, 0..DEPTH
//   buffer_empty         : occupancy == 0
//   buffer_full          : occupancy == DEPTH
//   overflow_err         : sticky dropped-write flag (see above)
// ----------------------------------------------------------------------------
module rx_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_rx_data,
    input  logic       flush,
    output logic [7:0] rx_data,
    output logic [6:0] buffer_occupancy,
    output logic       buffer_empty,
    output logic       buffer_full,
    output logic       overflow_err
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]    occ_q, occ_d;

    logic empty, full;
    logic do_wr, do_rd;

    assign empty = (occ_q == 7'd0);
    assign full  = (occ_q == 7'(DEPTH));

    // A read frees the head slot in the same cycle, so a full buffer still
    // accepts a write when a read accompanies it. When full, wr_ptr equals
    // rd_ptr: the new byte lands in the slot being consumed.
    assign do_rd = get_rx_data && !empty;
    assign do_wr = store_rx_packet_data && (!full || get_rx_data);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            // Contents are left alone; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = 7'd0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = rx_packet_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + {6'd0, do_wr} - {6'd0, do_rd};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= 7'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

`ifdef RX_BUFFER_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (flush) begin
            ovf_d = 1'b0;
        end else if (store_rx_packet_data && full && !get_rx_data) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_err = ovf_q;
`else
    assign overflow_err = 1'b0;
`endif

    // When empty, rx_data holds whatever the array has at rd_ptr (stable).
    assign rx_data          = mem_q[rd_ptr_q];
    assign buffer_occupancy = occ_q;
    assign buffer_empty     = empty;
    assign buffer_full      = full;

endmodule
